// File: rtl/alu_mc.sv
// Handshaked multi-cycle RV32I-style ALU with registered result, zero and illegal flags.
// Define ALU_MUL_EN to add an iterative radix-2 shift-add multiplier on encoding 1001.
module alu_mc #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

`ifdef ALU_MUL_EN
    localparam logic [3:0]  OP_MUL = 4'b1001;
    localparam int unsigned CW     = SHW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t state;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res_c;
    logic            base_ill_c;

    assign shamt = op2[SHW-1:0];

    // Single-cycle result for every base encoding, evaluated on the live operands at accept.
    always_comb begin
        base_res_c = '0;
        base_ill_c = 1'b0;
        case (alu_op)
            OP_ADD:  base_res_c = op1 + op2;
            OP_SUB:  base_res_c = op1 - op2;
            OP_SLL:  base_res_c = op1 << shamt;
            OP_SLT:  base_res_c = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: base_res_c = {{(XLEN-1){1'b0}}, (op1 < op2)};
            OP_XOR:  base_res_c = op1 ^ op2;
            OP_SRL:  base_res_c = op1 >> shamt;
            OP_SRA:  base_res_c = $unsigned($signed(op1) >>> shamt);
            OP_OR:   base_res_c = op1 | op2;
            OP_AND:  base_res_c = op1 & op2;
            default: base_ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_MUL_EN
                        if (alu_op == OP_MUL) begin
                            mcand  <= op1;
                            mplier <= op2;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= BUSY;
                        end else
`endif
                        begin
                            res       <= base_res_c;
                            zero      <= (base_res_c == '0);
                            illegal   <= base_ill_c;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                // XLEN shift-add steps, then one edge to publish the accumulator.
                BUSY: begin
                    if (cnt == CW'(XLEN)) begin
                        res       <= acc;
                        zero      <= (acc == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked, multi-cycle ALU for the next-generation core EX stage.
- Extends the existing pure-combinational ALU with the following:
  - Width parameter.
  - Full RV32I register-register op set, including SUB, SRA and SLTU.
  - Registered result with valid/ready flow control.
  - Illegal-op flag.
  - Optional iterative multiplier.
- Sits between operand read (ID/EX) and writeback. The stall logic uses `in_ready` and `out_valid`.

Parameters:
- XLEN, 32, operand/result width (>=8, power of two); SHW = log2(XLEN) is derived internally.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an op
- op1  in  XLEN  first operand
- op2  in  XLEN  second operand
- alu_op  in  4  operation code {funct7[5], funct3}
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- res  out  XLEN  result
- zero  out  1  res == 0
- illegal  out  1  alu_op was not a supported encoding

Behaviour:
- Reset is asynchronous, active-high, on clk/rst. On reset:
  - state=IDLE, in_ready=1, out_valid=0, res=0, zero=1, illegal=0.
  - An in-flight operation is discarded and never reported.
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready. Op1, op2 and alu_op are captured on that edge; later input changes are ignored.
    - Base op → DONE.
    - MUL (feature on) → BUSY.
  - BUSY: in_ready=0. One multiplier step per cycle, count from 0 to XLEN-1; on the last step → DONE.
  - DONE: out_valid=1, in_ready=0. res/zero/illegal are held stable until out_ready=1; that edge → IDLE.
- No accept in the same cycle as a result is drained; max throughput is one base op per 2 cycles.
- Latency:
  - Base op: accept edge N → out_valid high after edge N, i.e. 1 cycle.
  - MUL: out_valid high after edge N+XLEN+1.
- Encodings, all XLEN bits, modulo-2^XLEN arithmetic:
  - 0000 ADD: op1+op2
  - 1000 SUB: op1-op2
  - 0001 SLL: op1 << op2[SHW-1:0]
  - 0010 SLT: signed op1<op2 → 1, else 0 (zero-extended, not all-ones)
  - 0011 SLTU: unsigned compare, same 1/0 result
  - 0100 XOR
  - 0101 SRL: logical right shift by op2[SHW-1:0]
  - 1101 SRA: arithmetic right shift by op2[SHW-1:0]
  - 0110 OR
  - 0111 AND
  - 1001 MUL: optional, see below
- Shift amount uses only op2[SHW-1:0]; upper op2 bits are ignored. A shift by 0 returns op1.
- Any other encoding → DONE after 1 cycle with res=0, zero=1, illegal=1. Never hangs.
- zero and illegal are registered alongside res; they are valid only while out_valid=1.
- Reset asserted in BUSY or DONE → immediately IDLE, out_valid=0. The next accept after reset release behaves normally.
- in_valid asserted while in_ready=0 is ignored; the producer must hold it.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Encoding 1001 = MUL, low XLEN bits of op1*op2 (sign-agnostic).
  - Implemented as a radix-2 shift-add: the accumulator adds the multiplicand when the multiplier LSB=1, then the multiplicand shifts left and the multiplier shifts right, XLEN steps in BUSY.
  - illegal=0.
- Not defined:
  - No BUSY state and no multiplier registers are synthesised.
  - 1001 is handled as illegal: 1-cycle latency, res=0, illegal=1.

Test Plan:
- After reset, ADD 0x7FFFFFFF+0x00000001, out_ready=1 → out_valid 1 cycle after accept, res=0x80000000, zero=0, illegal=0; back in IDLE next cycle.
- SUB 5-5 → res=0, zero=1. SLT 0xFFFFFFFF vs 1 → res=1. SLTU 0xFFFFFFFF vs 1 → res=0.
- SRA 0x80000000 by op2=0x00000024 (amount 4) → 0xF8000000. SRL same operands → 0x08000000. SLL 1 by 31 → 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after result → out_valid, res and in_ready=0 stable. Toggle in_valid/op1 meanwhile → no effect. Release → drained.
- alu_op=1010 → res=0, illegal=1, latency 1. With ALU_MUL_EN: MUL 0x0000FFFF*0x00010001 → 0xFFFFFFFF after XLEN+1 cycles. Without it: 1001 → illegal=1.
- Assert rst mid-BUSY (MUL, cycle 10) → out_valid=0, in_ready=1 immediately. Subsequent ADD 2+3 → res=5. Repeat all with XLEN=16.
